// File: rtl/core_types_pkg.sv
// rtl/core_types_pkg.sv - shared rename-stage sizes and tag/pointer types
package core_types_pkg;
    localparam int NUM_ARCH_REGS          = 32;
    localparam int NUM_PHYS_REGS          = 64;
    localparam int PHYS_REG_WIDTH         = 6;
    localparam int FREE_LIST_DEPTH        = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int LOG_FREE_LIST_DEPTH    = $clog2(FREE_LIST_DEPTH);
    localparam int CHECKPOINT_COLUMNS     = 4;
    localparam int LOG_CHECKPOINT_COLUMNS = $clog2(CHECKPOINT_COLUMNS);

    typedef logic [PHYS_REG_WIDTH-1:0]         phys_reg_tag_t;
    typedef logic [LOG_CHECKPOINT_COLUMNS-1:0] checkpoint_column_t;
    typedef logic [LOG_FREE_LIST_DEPTH:0]      free_list_ptr_t;
endpackage

// File: rtl/phys_reg_free_list.sv
// rtl/phys_reg_free_list.sv - circular free list of physical register tags
module phys_reg_free_list
    import core_types_pkg::*;
(
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              dequeue_valid,
    output logic                              dequeue_ready,
    output logic [PHYS_REG_WIDTH-1:0]         dequeue_phys_reg_tag,
    input  logic                              enqueue_valid,
    input  logic [PHYS_REG_WIDTH-1:0]         enqueue_phys_reg_tag,
    output logic                              enqueue_ready,
    input  logic                              save_valid,
    input  logic [LOG_CHECKPOINT_COLUMNS-1:0] save_column,
    input  logic                              restore_valid,
    input  logic [LOG_CHECKPOINT_COLUMNS-1:0] restore_column,
    input  logic                              revert_valid,
    output logic [LOG_FREE_LIST_DEPTH:0]      free_count
);
    phys_reg_tag_t  tags_q [FREE_LIST_DEPTH];
    free_list_ptr_t ckpt_q [CHECKPOINT_COLUMNS];
    free_list_ptr_t head_q, head_d;
    free_list_ptr_t tail_q, tail_d;
    free_list_ptr_t count;
    logic           empty, full, deq_fire, enq_fire;

    // Wrap bit makes the plain difference distinguish full from empty.
    assign count    = tail_q - head_q;
    assign empty    = (count == free_list_ptr_t'(0));
    assign full     = (count == free_list_ptr_t'(FREE_LIST_DEPTH));
    assign deq_fire = dequeue_valid && !empty;
    assign enq_fire = enqueue_valid && !full;

    assign dequeue_ready        = !empty;
    assign enqueue_ready        = !full;
    assign free_count           = count;
    assign dequeue_phys_reg_tag = tags_q[head_q[LOG_FREE_LIST_DEPTH-1:0]];

    always_comb begin
        head_d = head_q;
        if (restore_valid) begin
            head_d = ckpt_q[restore_column];
        end else if (revert_valid) begin
            if (!full) head_d = head_q - free_list_ptr_t'(1);
        end else if (deq_fire) begin
            head_d = head_q + free_list_ptr_t'(1);
        end
    end

    assign tail_d = enq_fire ? tail_q + free_list_ptr_t'(1) : tail_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_q <= '0;
            tail_q <= free_list_ptr_t'(FREE_LIST_DEPTH);
            for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
                tags_q[i] <= phys_reg_tag_t'(NUM_ARCH_REGS + i);
            end
            for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
                ckpt_q[c] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            if (enq_fire) begin
                tags_q[tail_q[LOG_FREE_LIST_DEPTH-1:0]] <= enqueue_phys_reg_tag;
            end
            // Save captures the post-update head, so a same-cycle restore wins.
            if (save_valid) begin
                ckpt_q[save_column] <= head_d;
            end
        end
    end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb/tb_phys_reg_free_list.sv - self-checking bench for phys_reg_free_list
module tb_phys_reg_free_list;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       dequeue_valid = 1'b0;
    logic       dequeue_ready;
    logic [5:0] dequeue_phys_reg_tag;
    logic       enqueue_valid = 1'b0;
    logic [5:0] enqueue_phys_reg_tag = '0;
    logic       enqueue_ready;
    logic       save_valid = 1'b0;
    logic [1:0] save_column = '0;
    logic       restore_valid = 1'b0;
    logic [1:0] restore_column = '0;
    logic       revert_valid = 1'b0;
    logic [5:0] free_count;

    phys_reg_free_list dut (
        .CLK(CLK), .RST(RST),
        .dequeue_valid(dequeue_valid), .dequeue_ready(dequeue_ready),
        .dequeue_phys_reg_tag(dequeue_phys_reg_tag),
        .enqueue_valid(enqueue_valid), .enqueue_phys_reg_tag(enqueue_phys_reg_tag),
        .enqueue_ready(enqueue_ready),
        .save_valid(save_valid), .save_column(save_column),
        .restore_valid(restore_valid), .restore_column(restore_column),
        .revert_valid(revert_valid), .free_count(free_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: unbounded integer positions, reduced mod 64 / mod 32 on use.
    int m_head, m_tail;
    int m_mem [32];
    int m_ck  [4];

    function automatic void model_reset();
        m_head = 0;
        m_tail = 32;
        for (int i = 0; i < 32; i++) m_mem[i] = 32 + i;
        for (int c = 0; c < 4; c++) m_ck[c] = 0;
    endfunction

    function automatic int m_count();
        return (m_tail - m_head) & 63;
    endfunction

    task automatic check_model(input string name);
        chk({name, " tag"},   dequeue_phys_reg_tag, m_mem[m_head & 31]);
        chk({name, " ready"}, dequeue_ready, m_count() != 0);
        chk({name, " enq_ready"}, enqueue_ready, m_count() != 32);
        chk({name, " count"}, free_count, m_count());
    endtask

    task automatic drive(input string name, input logic d, input logic e, input logic [5:0] et,
                         input logic s, input logic [1:0] sc, input logic r, input logic [1:0] rc,
                         input logic rv);
        int c, nh;
        dequeue_valid = d; enqueue_valid = e; enqueue_phys_reg_tag = et;
        save_valid = s; save_column = sc; restore_valid = r; restore_column = rc;
        revert_valid = rv;
        c  = m_count();
        nh = m_head;
        if (r) nh = m_ck[rc];
        else if (rv) begin
            if (c != 32) nh = m_head - 1;
        end else if (d && c != 0) nh = m_head + 1;
        if (e && c != 32) begin
            m_mem[m_tail & 31] = et;
            m_tail++;
        end
        if (s) m_ck[sc] = nh;
        m_head = nh;
        @(posedge CLK);
        #1;
        dequeue_valid = 0; enqueue_valid = 0; save_valid = 0; restore_valid = 0; revert_valid = 0;
        check_model(name);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #2;
        RST = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, " tag"}, dequeue_phys_reg_tag, 32);
        chk({name, " ready"}, dequeue_ready, 1);
        chk({name, " enq_ready"}, enqueue_ready, 0);
        chk({name, " count"}, free_count, 32);
    endtask

    typedef struct {
        logic d, e, s, r, rv;
        logic [5:0] et;
        logic [1:0] sc, rc;
        int tag, rdy, erdy, cnt;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(logic d, logic e, logic [5:0] et, logic s, logic [1:0] sc,
                                logic r, logic [1:0] rc, logic rv, int tag, int cnt);
        vec_t v;
        v.d = d; v.e = e; v.et = et; v.s = s; v.sc = sc; v.r = r; v.rc = rc; v.rv = rv;
        v.tag = tag; v.cnt = cnt; v.rdy = (cnt != 0); v.erdy = (cnt != 32);
        return v;
    endfunction

    initial begin
        logic d, e, s, r, rv;
        logic [1:0] sc, rc;
        logic [5:0] et;
        model_reset();
        #12 RST = 1'b0;
        @(posedge CLK);
        #1;
        chk_reset_outputs("reset");

        // Drain all 32 tags in order, then a dequeue on empty changes nothing.
        for (int i = 0; i < 32; i++) begin
            chk("drain order", dequeue_phys_reg_tag, 32 + i);
            drive("drain", 1, 0, 0, 0, 0, 0, 0, 0);
        end
        chk("empty ready", dequeue_ready, 0);
        chk("empty count", free_count, 0);
        drive("deq on empty", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("deq on empty count", free_count, 0);

        // Enqueue into empty list: not visible until the next cycle.
        enqueue_valid = 1; enqueue_phys_reg_tag = 6'd5;
        #2;
        chk("no bypass ready", dequeue_ready, 0);
        drive("enq 5", 0, 1, 6'd5, 0, 0, 0, 0, 0);
        chk("enq 5 tag", dequeue_phys_reg_tag, 5);
        chk("enq 5 count", free_count, 1);
        for (int i = 0; i < 9; i++) drive("fill", 0, 1, 6'(10 + i), 0, 0, 0, 0, 0);
        chk("fill count", free_count, 10);
        drive("enq+deq", 1, 1, 6'd7, 0, 0, 0, 0, 0);
        chk("enq+deq count", free_count, 10);
        chk("enq+deq tag", dequeue_phys_reg_tag, 10);
        for (int i = 0; i < 9; i++) begin
            chk("post-pair order", dequeue_phys_reg_tag, 10 + i);
            drive("post-pair", 1, 0, 0, 0, 0, 0, 0, 0);
        end
        chk("tag 7 at old tail", dequeue_phys_reg_tag, 7);

        // Checkpoint/restore/revert table, applied from reset.
        do_reset();
        chk_reset_outputs("reset2");
        vecs.push_back(mk(1,0,0, 0,0, 0,0, 0, 33, 31));
        vecs.push_back(mk(1,0,0, 0,0, 0,0, 0, 34, 30));
        vecs.push_back(mk(1,0,0, 0,0, 0,0, 0, 35, 29));
        vecs.push_back(mk(0,0,0, 1,2, 0,0, 0, 35, 29));
        vecs.push_back(mk(1,0,0, 0,0, 0,0, 0, 36, 28));
        vecs.push_back(mk(1,0,0, 0,0, 0,0, 0, 37, 27));
        vecs.push_back(mk(1,0,0, 0,0, 0,0, 0, 38, 26));
        vecs.push_back(mk(1,0,0, 0,0, 0,0, 0, 39, 25));
        vecs.push_back(mk(1,0,0, 0,0, 1,2, 0, 35, 29));
        vecs.push_back(mk(0,0,0, 0,0, 0,0, 1, 34, 30));
        vecs.push_back(mk(0,0,0, 0,0, 0,0, 1, 33, 31));
        vecs.push_back(mk(0,0,0, 0,0, 0,0, 1, 32, 32));
        vecs.push_back(mk(0,0,0, 0,0, 0,0, 1, 32, 32));
        vecs.push_back(mk(0,1,9, 0,0, 0,0, 0, 32, 32));
        vecs.push_back(mk(1,0,0, 1,1, 0,0, 0, 33, 31));
        vecs.push_back(mk(1,0,0, 0,0, 0,0, 0, 34, 30));
        vecs.push_back(mk(0,0,0, 1,3, 1,0, 0, 32, 32));
        vecs.push_back(mk(1,0,0, 0,0, 0,0, 0, 33, 31));
        vecs.push_back(mk(0,0,0, 0,0, 1,3, 0, 32, 32));
        vecs.push_back(mk(1,0,0, 0,0, 0,0, 0, 33, 31));
        vecs.push_back(mk(0,0,0, 1,2, 1,2, 0, 35, 29));
        vecs.push_back(mk(1,0,0, 0,0, 0,0, 0, 36, 28));
        vecs.push_back(mk(0,0,0, 0,0, 1,2, 0, 35, 29));
        vecs.push_back(mk(0,0,0, 0,0, 1,1, 0, 33, 31));
        for (int i = 0; i < vecs.size(); i++) begin
            drive("vec model", vecs[i].d, vecs[i].e, vecs[i].et, vecs[i].s, vecs[i].sc,
                  vecs[i].r, vecs[i].rc, vecs[i].rv);
            chk($sformatf("vec%0d tag", i), dequeue_phys_reg_tag, vecs[i].tag);
            chk($sformatf("vec%0d ready", i), dequeue_ready, vecs[i].rdy);
            chk($sformatf("vec%0d enq_ready", i), enqueue_ready, vecs[i].erdy);
            chk($sformatf("vec%0d count", i), free_count, vecs[i].cnt);
        end

        // Wrap-around: 40 enqueue/dequeue pairs with a few tags in flight.
        do_reset();
        for (int i = 0; i < 5; i++) drive("wrap pre", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) drive("wrap", 1, 1, 6'($urandom_range(0, 63)), 0, 0, 0, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            d  = ($urandom_range(0, 99) < 50);
            e  = ($urandom_range(0, 99) < 50);
            et = 6'($urandom_range(0, 63));
            s  = ($urandom_range(0, 99) < 15);
            sc = 2'($urandom_range(0, 3));
            r  = ($urandom_range(0, 99) < 5);
            rc = 2'($urandom_range(0, 3));
            rv = ($urandom_range(0, 99) < 8) && (m_count() != 32);
            drive("random", d, e, et, s, sc, r, rc, rv);
        end

        // Asynchronous reset between edges.
        drive("pre-async", 1, 0, 0, 0, 0, 0, 0, 0);
        drive("pre-async", 1, 0, 0, 0, 0, 0, 0, 0);
        #2;
        RST = 1'b1;
        #1;
        chk_reset_outputs("async reset");
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        drive("after async", 1, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
